hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_pkg.sv | 22 ++
 rtl/hazard_scoreboard_decode.sv | 56 +++++
 rtl/hazard_scoreboard.sv | 89 ++++++++
 tb/tb_hazard_scoreboard.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared decode constants and scoreboard entry type for the ID-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam int unsigned FWD_REGFILE = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_decode.sv
// Operand usage / destination decode for one instruction, by opcode class.
module hazard_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [31:0] inst,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        writes_rd,
  output logic        is_load,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  // funct3/funct7 do not affect hazard classification.
  logic unused_bits;
  assign unused_bits = ^{inst[31:25], inst[14:12]};

  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign rd  = inst[11:7];

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        is_load   = 1'b1;
      end
      OPC_OP_IMM: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Multi-stage destination scoreboard: nearest-producer forwarding select and load-use stall.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter  int unsigned STAGES      = 3,
  parameter  int unsigned LOAD_LAT    = 1,
  parameter  int unsigned STALL_CNT_W = 16,
  localparam int unsigned SEL_W       = $clog2(STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [31:0]            id_inst,
  input  logic                   flush,
  input  logic                   ext_stall,
  output logic                   stall_o,
  output logic [SEL_W-1:0]       fwd_rs1_sel,
  output logic [SEL_W-1:0]       fwd_rs2_sel,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic       uses_rs1, uses_rs2, writes_rd, is_load;
  logic [4:0] rs1, rs2, rd;

  hazard_decode u_decode (
    .inst      (id_inst),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd)
  );

  sb_entry_t        sb_q [1:STAGES];
  sb_entry_t        new_entry;
  logic             live;
  logic [SEL_W-1:0] rs1_sel, rs2_sel;
  logic             rs1_late, rs2_late;

  assign live = id_valid & ~flush;

  // Scan from the oldest stage down so the nearest producer overwrites farther ones.
  always_comb begin
    rs1_sel  = '0;
    rs2_sel  = '0;
    rs1_late = 1'b0;
    rs2_late = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (live && uses_rs1 && sb_q[k].valid && (sb_q[k].rd == rs1)) begin
        rs1_sel  = SEL_W'(k);
        rs1_late = sb_q[k].is_load && (k <= int'(LOAD_LAT));
      end
      if (live && uses_rs2 && sb_q[k].valid && (sb_q[k].rd == rs2)) begin
        rs2_sel  = SEL_W'(k);
        rs2_late = sb_q[k].is_load && (k <= int'(LOAD_LAT));
      end
    end
  end

  assign stall_o     = rs1_late | rs2_late;
  assign fwd_rs1_sel = stall_o ? SEL_W'(FWD_REGFILE) : rs1_sel;
  assign fwd_rs2_sel = stall_o ? SEL_W'(FWD_REGFILE) : rs2_sel;

  always_comb begin
    new_entry.valid   = live & ~stall_o & writes_rd & (rd != 5'd0);
    new_entry.rd      = rd;
    new_entry.is_load = is_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= STAGES; k++) sb_q[k] <= '0;
    end else if (!ext_stall) begin
      for (int k = 2; k <= STAGES; k++) sb_q[k] <= sb_q[k-1];
      sb_q[1] <= new_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_o && !ext_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed pipeline scenarios plus random traffic against a behavioural model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        flush;
  logic        ext_stall;

  logic        stall0, stall1;
  logic [1:0]  s1_0, s2_0;
  logic [2:0]  s1_1, s2_1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.STAGES(3), .LOAD_LAT(1), .STALL_CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
    .ext_stall(ext_stall), .stall_o(stall0), .fwd_rs1_sel(s1_0), .fwd_rs2_sel(s2_0),
    .stall_cnt(cnt0)
  );

  hazard_scoreboard #(.STAGES(4), .LOAD_LAT(2), .STALL_CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .flush(flush),
    .ext_stall(ext_stall), .stall_o(stall1), .fwd_rs1_sel(s1_1), .fwd_rs2_sel(s2_1),
    .stall_cnt(cnt1)
  );

  // ---------------- behavioural model: list of in-flight producers per config
  int cfg_stages [2] = '{3, 4};
  int cfg_lat    [2] = '{1, 2};
  int cfg_max    [2] = '{65535, 7};
  bit m_v  [2][8];
  int m_rd [2][8];
  bit m_ld [2][8];
  int m_cnt[2];

  function automatic void classify(input logic [31:0] i, output bit u1, output bit u2,
                                   output bit w, output bit ld);
    logic [6:0] o;
    o  = i[6:0];
    w  = o inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33};
    u1 = o inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    u2 = o inside {7'h63, 7'h23, 7'h33};
    ld = (o == 7'h03);
  endfunction

  function automatic int nearest(input int c, input int r);
    for (int k = 1; k <= cfg_stages[c]; k++)
      if (m_v[c][k] && m_rd[c][k] == r) return k;
    return 0;
  endfunction

  function automatic void predict(input int c, output bit st, output int e1, output int e2);
    bit u1, u2, w, ld, live;
    int k1, k2;
    classify(id_inst, u1, u2, w, ld);
    live = id_valid && !flush;
    k1 = (live && u1) ? nearest(c, int'(id_inst[19:15])) : 0;
    k2 = (live && u2) ? nearest(c, int'(id_inst[24:20])) : 0;
    st = (k1 != 0 && m_ld[c][k1] && k1 <= cfg_lat[c]) ||
         (k2 != 0 && m_ld[c][k2] && k2 <= cfg_lat[c]);
    e1 = st ? 0 : k1;
    e2 = st ? 0 : k2;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 8; k++) begin
        m_v[c][k] = 0; m_rd[c][k] = 0; m_ld[c][k] = 0;
      end
      m_cnt[c] = 0;
    end
  endtask

  task automatic model_clock();
    bit st, u1, u2, w, ld;
    int e1, e2;
    for (int c = 0; c < 2; c++) begin
      predict(c, st, e1, e2);
      if (!ext_stall) begin
        classify(id_inst, u1, u2, w, ld);
        for (int k = cfg_stages[c]; k >= 2; k--) begin
          m_v[c][k] = m_v[c][k-1]; m_rd[c][k] = m_rd[c][k-1]; m_ld[c][k] = m_ld[c][k-1];
        end
        m_v[c][1]  = id_valid && !flush && !st && w && (id_inst[11:7] != 5'd0);
        m_rd[c][1] = int'(id_inst[11:7]);
        m_ld[c][1] = ld;
        if (st && m_cnt[c] < cfg_max[c]) m_cnt[c]++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_clock();
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // Compare both DUTs to the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    bit st;
    int e1, e2;
    if (!rst) begin
      predict(0, st, e1, e2);
      chk("m0_stall", 64'(stall0), 64'(st));
      chk("m0_sel1", 64'(s1_0), 64'(e1));
      chk("m0_sel2", 64'(s2_0), 64'(e2));
      chk("m0_cnt", 64'(cnt0), 64'(m_cnt[0]));
      predict(1, st, e1, e2);
      chk("m1_stall", 64'(stall1), 64'(st));
      chk("m1_sel1", 64'(s1_1), 64'(e1));
      chk("m1_sel2", 64'(s2_1), 64'(e2));
      chk("m1_cnt", 64'(cnt1), 64'(m_cnt[1]));
    end
  end

  // ---------------- encoders
  function automatic logic [31:0] r_op(input int rd, input int a, input int b, input bit sub);
    return {sub ? 7'b0100000 : 7'b0, 5'(b), 5'(a), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input int rd, input int a, input int imm);
    return {12'(imm), 5'(a), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] i_lw(input int rd, input int a);
    return {12'd0, 5'(a), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] s_sw(input int b, input int a);
    return {7'd0, 5'(b), 5'(a), 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] u_lui(input int rd, input int imm);
    return {20'(imm), 5'(rd), 7'b0110111};
  endfunction

  task automatic step(input logic [31:0] inst, input bit v, input bit fl, input bit es);
    @(posedge clk);
    #1;
    id_inst = inst; id_valid = v; flush = fl; ext_stall = es;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (5) step(32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lit(input string name, input bit st, input int e1, input int e2,
                     input int c);
    chk({name, "_stall"}, 64'(stall0), 64'(st));
    chk({name, "_sel1"}, 64'(s1_0), 64'(e1));
    chk({name, "_sel2"}, 64'(s2_0), 64'(e2));
    chk({name, "_cnt"}, 64'(cnt0), 64'(c));
  endtask

  initial begin
    logic [6:0] opcs [11];
    logic [31:0] ri;
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    rst = 1'b1; id_valid = 1'b0; id_inst = '0; flush = 1'b0; ext_stall = 1'b0;
    #3;
    chk("rst_stall", 64'(stall0), 64'd0);
    chk("rst_cnt", 64'(cnt0), 64'd0);
    #9 rst = 1'b0;

    // ALU dependence forwards from EX.
    step(r_op(5, 1, 2, 0), 1, 0, 0);
    lit("alu_first", 0, 0, 0, 0);
    step(r_op(6, 5, 3, 1), 1, 0, 0);
    lit("alu_dep", 0, 1, 0, 0);
    drain();

    // Load-use: one stall cycle, then forward from MEM.
    step(i_lw(5, 1), 1, 0, 0);
    step(r_op(7, 5, 5, 0), 1, 0, 0);
    lit("lu_stall", 1, 0, 0, 0);
    step(r_op(7, 5, 5, 0), 1, 0, 0);
    lit("lu_fwd", 0, 2, 2, 1);
    drain();

    // Nearest producer wins; a bubble pushes it one stage out.
    step(i_addi(5, 0, 1), 1, 0, 0);
    step(i_addi(5, 0, 2), 1, 0, 0);
    step(s_sw(5, 5), 1, 0, 0);
    lit("near", 0, 1, 1, 1);
    drain();
    step(i_addi(5, 0, 1), 1, 0, 0);
    step(i_addi(5, 0, 2), 1, 0, 0);
    step(32'd0, 0, 0, 0);
    step(s_sw(5, 5), 1, 0, 0);
    lit("near_bub", 0, 2, 2, 1);
    drain();

    // x0 never tracked; LUI has no sources.
    step(i_addi(0, 1, 4), 1, 0, 0);
    step(r_op(2, 0, 0, 0), 1, 0, 0);
    lit("x0", 0, 0, 0, 1);
    step(i_addi(9, 0, 1), 1, 0, 0);
    step(u_lui(9, 1), 1, 0, 0);
    lit("lui", 0, 0, 0, 1);
    drain();

    // Flush beats the hazard and injects a bubble.
    step(i_lw(5, 1), 1, 0, 0);
    step(r_op(6, 5, 0, 0), 1, 1, 0);
    lit("flush", 0, 0, 0, 1);
    step(r_op(1, 6, 5, 0), 1, 0, 0);
    lit("flush_bub", 0, 0, 2, 1);
    drain();

    // External freeze during a load-use stall.
    step(i_lw(5, 1), 1, 0, 0);
    repeat (3) begin
      step(r_op(7, 5, 5, 0), 1, 0, 1);
      lit("frz", 1, 0, 0, 1);
    end
    step(r_op(7, 5, 5, 0), 1, 0, 0);
    lit("frz_rel", 1, 0, 0, 1);
    step(r_op(7, 5, 5, 0), 1, 0, 0);
    lit("frz_done", 0, 2, 2, 2);
    drain();

    // Asynchronous reset in the middle of a stall.
    step(i_lw(5, 1), 1, 0, 0);
    step(r_op(7, 5, 5, 0), 1, 0, 0);
    lit("pre_rst", 1, 0, 0, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall", 64'(stall0), 64'd0);
    chk("arst_cnt", 64'(cnt0), 64'd0);
    chk("arst_sel1", 64'(s1_0), 64'd0);
    #1 rst = 1'b0;

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      ri = $urandom;
      ri[6:0]   = opcs[$urandom_range(0, 10)];
      ri[11:7]  = 5'($urandom_range(0, 4));
      ri[19:15] = 5'($urandom_range(0, 4));
      ri[24:20] = 5'($urandom_range(0, 4));
      @(posedge clk);
      #1;
      id_inst   = ri;
      id_valid  = ($urandom_range(0, 99) < 85);
      flush     = ($urandom_range(0, 99) < 10);
      ext_stall = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 999) < 3) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
